// File: rtl/pc_pkg.sv
// Shared types for the next-PC sequencer: control ops, fault causes, FSM states.
package pc_pkg;

  localparam int PC_ADDR_W = 11;

  typedef enum logic [2:0] {
    OP_SEQ    = 3'd0,
    OP_JUMP   = 3'd1,
    OP_BRANCH = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4
  } pc_op_t;

  typedef enum logic [1:0] {
    FC_NONE      = 2'd0,
    FC_OVERFLOW  = 2'd1,
    FC_UNDERFLOW = 2'd2,
    FC_ILLEGAL   = 2'd3
  } fault_cause_t;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

endpackage

// File: rtl/return_stack.sv
// Hardware return-address stack: register array addressed by the occupancy count.
// Only the count is reset; entry contents are meaningless while not occupied.
module return_stack #(
  parameter int ADDR_W      = 11,
  parameter int STACK_DEPTH = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             push,
  input  logic                             pop,
  input  logic [ADDR_W-1:0]                push_data,
  output logic [ADDR_W-1:0]                top,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(STACK_DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int PTR_W = $clog2(STACK_DEPTH);

  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic [CNT_W-1:0]  top_idx;
  logic [PTR_W-1:0]  wr_idx;

  assign full    = (count_q == CNT_W'(STACK_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign wr_idx  = count_q[PTR_W-1:0];
  assign top_idx = count_q - CNT_W'(1);
  assign top     = mem_q[top_idx[PTR_W-1:0]];

  // Occupancy moves by at most one per cycle; push/pop past the limits is refused.
  always_comb begin
    count_d = count_q;
    if (push && !full) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !empty) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Occupancy register, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Entry storage; written at the slot just above the current top.
  always_ff @(posedge clock) begin
    if (push && !full) begin
      mem_q[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/next_pc_sequencer.sv
// Next-PC selection in front of the PC register: boot vector, sequential/jump/branch,
// call/return through a hardware return stack, and a sticky fault vector on misuse.
module next_pc_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W       = PC_ADDR_W,
  parameter int                STACK_DEPTH  = 8,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0] FAULT_VECTOR = ADDR_W'(11'h7F0)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [ADDR_W-1:0]                pc_current,
  input  logic [2:0]                       op,
  input  logic                             branch_taken,
  input  logic [ADDR_W-1:0]                target,
  input  logic                             stall,
  output logic [ADDR_W-1:0]                next_pc,
  output logic                             fault,
  output logic [1:0]                       fault_cause,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count
);

  state_t            state_q, state_d;
  logic              fault_q, fault_d;
  fault_cause_t      cause_q, cause_d;
  pc_op_t            op_e;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_push, stk_pop, stk_full, stk_empty;
  logic              take_fault;

  assign op_e        = pc_op_t'(op);
  assign pc_plus1    = pc_current + ADDR_W'(1);
  assign fault       = fault_q;
  assign fault_cause = cause_q;

  return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_plus1),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty),
    .count     (stack_count)
  );

  // Next-PC mux, stack control and fault detection for the current cycle.
  always_comb begin
    state_d    = state_q;
    fault_d    = fault_q;
    cause_d    = cause_q;
    next_pc    = pc_plus1;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    take_fault = 1'b0;
    case (state_q)
      S_BOOT: begin
        next_pc = RESET_VECTOR;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (stall) begin
          next_pc = pc_current;
        end else begin
          case (op_e)
            OP_SEQ:    next_pc = pc_plus1;
            OP_JUMP:   next_pc = target;
            OP_BRANCH: next_pc = branch_taken ? target : pc_plus1;
            OP_CALL: begin
              if (stk_full) begin
                take_fault = 1'b1;
                cause_d    = FC_OVERFLOW;
              end else begin
                stk_push = 1'b1;
                next_pc  = target;
              end
            end
            OP_RET: begin
              if (stk_empty) begin
                take_fault = 1'b1;
                cause_d    = FC_UNDERFLOW;
              end else begin
                stk_pop = 1'b1;
                next_pc = stk_top;
              end
            end
            default: begin
              take_fault = 1'b1;
              cause_d    = FC_ILLEGAL;
            end
          endcase
          if (take_fault) begin
            next_pc = FAULT_VECTOR;
            fault_d = 1'b1;
            state_d = S_FAULT;
          end
        end
      end
      default: begin
        // S_FAULT and the unused encoding both park on the fault vector.
        next_pc = FAULT_VECTOR;
      end
    endcase
  end

  // FSM state and registered fault outputs; reset wins over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_BOOT;
      fault_q <= 1'b0;
      cause_q <= FC_NONE;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
    end
  end

endmodule

// File: tb/tb_next_pc_sequencer.sv
// Self-checking bench for next_pc_sequencer: expected next_pc values are queued as
// stimulus is applied and popped when the combinational output is sampled.
module tb_next_pc_sequencer;
  import pc_pkg::*;

  localparam int ADDR_W      = 11;
  localparam int STACK_DEPTH = 8;
  localparam int CNT_W       = $clog2(STACK_DEPTH + 1);

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] pc_current = '0;
  logic [2:0]        op = 3'd0;
  logic              branch_taken = 1'b0;
  logic [ADDR_W-1:0] target = '0;
  logic              stall = 1'b0;
  logic [ADDR_W-1:0] next_pc;
  logic              fault;
  logic [1:0]        fault_cause;
  logic [CNT_W-1:0]  stack_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] want;

  next_pc_sequencer #(
    .ADDR_W       (ADDR_W),
    .STACK_DEPTH  (STACK_DEPTH),
    .RESET_VECTOR (11'h000),
    .FAULT_VECTOR (11'h7F0)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .pc_current   (pc_current),
    .op           (op),
    .branch_taken (branch_taken),
    .target       (target),
    .stall        (stall),
    .next_pc      (next_pc),
    .fault        (fault),
    .fault_cause  (fault_cause),
    .stack_count  (stack_count)
  );

  always #5 clock = ~clock;

  // Drive one cycle of stimulus at the falling edge and queue the expected next_pc.
  task automatic apply(input logic [2:0] o, input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] tgt,
                       input logic tk, input logic st, input logic [ADDR_W-1:0] exp_pc);
    @(negedge clock);
    op = o; pc_current = pc; target = tgt; branch_taken = tk; stall = st;
    exp_q.push_back(exp_pc);
    #1;
  endtask

  // One reset cycle, then release; leaves the bench sitting in the boot cycle.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    op = OP_CALL; pc_current = 11'h055; target = 11'h3AA; stall = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    exp_q.push_back(11'h000);
    want = exp_q.pop_front(); n_cmp++;
    if (next_pc !== want) begin n_err++; $display("FAIL boot_vector: next_pc=%h expected %h", next_pc, want); end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: fault=%b expected 0", fault); end
    n_cmp++; if (fault_cause !== 2'd0) begin n_err++; $display("FAIL reset_cause: cause=%0d expected 0", fault_cause); end
    n_cmp++; if (stack_count !== '0) begin n_err++; $display("FAIL reset_count: count=%0d expected 0", stack_count); end
    apply(OP_SEQ, 11'h000, 11'h000, 1'b0, 1'b0, 11'h001);
    want = exp_q.pop_front(); n_cmp++;
    if (next_pc !== want) begin n_err++; $display("FAIL first_seq: next_pc=%h expected %h", next_pc, want); end
    n_cmp++; if (stack_count !== '0) begin n_err++; $display("FAIL boot_ignores_call: count=%0d expected 0", stack_count); end
  endtask

  task automatic test_seq_jump();
    apply(OP_SEQ, 11'h7FF, 11'h000, 1'b0, 1'b0, 11'h000);
    want = exp_q.pop_front(); n_cmp++;
    if (next_pc !== want) begin n_err++; $display("FAIL seq_wrap: next_pc=%h expected %h", next_pc, want); end
    apply(OP_JUMP, 11'h010, 11'h123, 1'b0, 1'b0, 11'h123);
    want = exp_q.pop_front(); n_cmp++;
    if (next_pc !== want) begin n_err++; $display("FAIL jump: next_pc=%h expected %h", next_pc, want); end
  endtask

  task automatic test_branch();
    apply(OP_BRANCH, 11'h010, 11'h040, 1'b0, 1'b0, 11'h011);
    want = exp_q.pop_front(); n_cmp++;
    if (next_pc !== want) begin n_err++; $display("FAIL branch_not_taken: next_pc=%h expected %h", next_pc, want); end
    apply(OP_BRANCH, 11'h010, 11'h040, 1'b1, 1'b0, 11'h040);
    want = exp_q.pop_front(); n_cmp++;
    if (next_pc !== want) begin n_err++; $display("FAIL branch_taken: next_pc=%h expected %h", next_pc, want); end
  endtask

  task automatic test_call_ret();
    logic [2:0]        ops  [7] = '{OP_CALL, OP_CALL, OP_RET, OP_RET, OP_CALL, OP_RET, OP_SEQ};
    logic [ADDR_W-1:0] pcs  [7] = '{11'h010, 11'h105, 11'h200, 11'h106, 11'h7FF, 11'h123, 11'h011};
    logic [ADDR_W-1:0] tgts [7] = '{11'h100, 11'h200, 11'h000, 11'h000, 11'h123, 11'h000, 11'h000};
    logic [ADDR_W-1:0] exps [7] = '{11'h100, 11'h200, 11'h106, 11'h011, 11'h123, 11'h000, 11'h012};
    logic [CNT_W-1:0]  cnts [7] = '{4'd0, 4'd1, 4'd2, 4'd1, 4'd0, 4'd1, 4'd0};
    for (int i = 0; i < 7; i++) begin
      apply(ops[i], pcs[i], tgts[i], 1'b0, 1'b0, exps[i]);
      want = exp_q.pop_front(); n_cmp++;
      if (next_pc !== want) begin n_err++; $display("FAIL call_ret[%0d]: next_pc=%h expected %h", i, next_pc, want); end
      n_cmp++;
      if (stack_count !== cnts[i]) begin n_err++; $display("FAIL call_ret_count[%0d]: count=%0d expected %0d", i, stack_count, cnts[i]); end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < STACK_DEPTH; i++) begin
      apply(OP_CALL, ADDR_W'(i * 16), ADDR_W'(11'h300 + i), 1'b0, 1'b0, ADDR_W'(11'h300 + i));
      want = exp_q.pop_front(); n_cmp++;
      if (next_pc !== want) begin n_err++; $display("FAIL fill_call[%0d]: next_pc=%h expected %h", i, next_pc, want); end
    end
    // RET while full is legal and returns the most recent push (0x070 + 1).
    apply(OP_RET, 11'h307, 11'h000, 1'b0, 1'b0, 11'h071);
    want = exp_q.pop_front(); n_cmp++;
    if (next_pc !== want) begin n_err++; $display("FAIL ret_at_full: next_pc=%h expected %h", next_pc, want); end
    n_cmp++; if (stack_count !== 4'd8) begin n_err++; $display("FAIL count_full: count=%0d expected 8", stack_count); end
    apply(OP_CALL, 11'h600, 11'h601, 1'b0, 1'b0, 11'h601);
    want = exp_q.pop_front(); n_cmp++;
    if (next_pc !== want) begin n_err++; $display("FAIL refill_call: next_pc=%h expected %h", next_pc, want); end
    n_cmp++; if (stack_count !== 4'd7) begin n_err++; $display("FAIL count_after_ret: count=%0d expected 7", stack_count); end
    apply(OP_CALL, 11'h400, 11'h500, 1'b0, 1'b0, 11'h7F0);
    want = exp_q.pop_front(); n_cmp++;
    if (next_pc !== want) begin n_err++; $display("FAIL overflow_detect: next_pc=%h expected %h", next_pc, want); end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL fault_early: fault=%b expected 0", fault); end
    apply(OP_RET, 11'h7F0, 11'h000, 1'b0, 1'b0, 11'h7F0);
    want = exp_q.pop_front(); n_cmp++;
    if (next_pc !== want) begin n_err++; $display("FAIL fault_hold: next_pc=%h expected %h", next_pc, want); end
    n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL overflow_fault: fault=%b expected 1", fault); end
    n_cmp++; if (fault_cause !== 2'd1) begin n_err++; $display("FAIL overflow_cause: cause=%0d expected 1", fault_cause); end
    n_cmp++; if (stack_count !== 4'd8) begin n_err++; $display("FAIL overflow_no_push: count=%0d expected 8", stack_count); end
    apply(OP_JUMP, 11'h7F0, 11'h222, 1'b0, 1'b0, 11'h7F0);
    want = exp_q.pop_front(); n_cmp++;
    if (next_pc !== want) begin n_err++; $display("FAIL fault_sticky: next_pc=%h expected %h", next_pc, want); end
    n_cmp++; if (stack_count !== 4'd8) begin n_err++; $display("FAIL fault_frozen: count=%0d expected 8", stack_count); end
    do_reset();
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_clears_fault: fault=%b expected 0", fault); end
    n_cmp++; if (stack_count !== '0) begin n_err++; $display("FAIL reset_clears_count: count=%0d expected 0", stack_count); end
  endtask

  task automatic test_underflow_illegal_stall();
    apply(OP_RET, 11'h020, 11'h000, 1'b0, 1'b0, 11'h7F0);
    want = exp_q.pop_front(); n_cmp++;
    if (next_pc !== want) begin n_err++; $display("FAIL underflow_detect: next_pc=%h expected %h", next_pc, want); end
    apply(OP_SEQ, 11'h7F0, 11'h000, 1'b0, 1'b0, 11'h7F0);
    want = exp_q.pop_front(); n_cmp++;
    if (next_pc !== want) begin n_err++; $display("FAIL underflow_hold: next_pc=%h expected %h", next_pc, want); end
    n_cmp++; if (fault_cause !== 2'd2) begin n_err++; $display("FAIL underflow_cause: cause=%0d expected 2", fault_cause); end
    do_reset();
    apply(3'd6, 11'h030, 11'h000, 1'b0, 1'b0, 11'h7F0);
    want = exp_q.pop_front(); n_cmp++;
    if (next_pc !== want) begin n_err++; $display("FAIL illegal_detect: next_pc=%h expected %h", next_pc, want); end
    apply(OP_SEQ, 11'h7F0, 11'h000, 1'b0, 1'b0, 11'h7F0);
    want = exp_q.pop_front(); n_cmp++;
    if (next_pc !== want) begin n_err++; $display("FAIL illegal_hold: next_pc=%h expected %h", next_pc, want); end
    n_cmp++; if (fault !== 1'b1 || fault_cause !== 2'd3) begin n_err++; $display("FAIL illegal_cause: fault=%b cause=%0d expected 1/3", fault, fault_cause); end
    do_reset();
    apply(OP_CALL, 11'h040, 11'h100, 1'b0, 1'b1, 11'h040);
    want = exp_q.pop_front(); n_cmp++;
    if (next_pc !== want) begin n_err++; $display("FAIL stall_call: next_pc=%h expected %h", next_pc, want); end
    apply(3'd7, 11'h040, 11'h100, 1'b0, 1'b1, 11'h040);
    want = exp_q.pop_front(); n_cmp++;
    if (next_pc !== want) begin n_err++; $display("FAIL stall_illegal: next_pc=%h expected %h", next_pc, want); end
    n_cmp++; if (stack_count !== '0) begin n_err++; $display("FAIL stall_no_push: count=%0d expected 0", stack_count); end
    apply(OP_SEQ, 11'h040, 11'h000, 1'b0, 1'b0, 11'h041);
    want = exp_q.pop_front(); n_cmp++;
    if (next_pc !== want) begin n_err++; $display("FAIL after_stall: next_pc=%h expected %h", next_pc, want); end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL stall_no_fault: fault=%b expected 0", fault); end
  endtask

  initial begin
    test_reset();
    test_seq_jump();
    test_branch();
    test_call_ret();
    test_overflow();
    test_underflow_illegal_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
